cpu_ctrl_fsm: RTL and testbench
===============================

# cpu_ctrl_fsm

Multi-cycle control sequencer for the RV64 subset CPU. Drives instruction fetch and data-memory handshakes, holds the current instruction for the decode datapath (register file, immediate generator, ALU), and issues register-write and PC-update strobes once per retired instruction. Supported opcodes: R-type, I-type ALU, load, store, beq/bne, and the halt opcode.

## Interface
- `ADDR_W`, default 64: datapath width; only affects the width of `o_pc_inc`.
- `i_clk`  in  1  clock.
- `i_rst_n`  in  1  asynchronous active-low reset.
- `i_inst`  in  32  instruction word from instruction memory; valid with `i_i_valid_inst`.
- `i_i_valid_inst`  in  1  instruction-memory response strobe.
- `i_d_valid_data`  in  1  data-memory response strobe: load data valid, or store acknowledged.
- `i_alu_zero`  in  1  ALU zero flag, valid during EXEC.
- `o_inst`  out  32  latched instruction; feeds the register file and immediate generator.
- `o_i_MemRead`  out  1  instruction-fetch request pulse.
- `o_d_MemRead`  out  1  load request pulse.
- `o_d_MemWrite`  out  1  store request pulse.
- `o_alu_src`  out  1  1 = immediate operand (I-type, load, store); 0 = rs2.
- `o_alu_op`  out  2  00 add (load/store), 01 sub (branch), 10 funct-decoded (R/I).
- `o_mem_to_reg`  out  1  1 = write-back source is load data.
- `o_reg_write`  out  1  register-file write strobe.
- `o_pc_write`  out  1  PC update strobe.
- `o_pc_src`  out  1  1 = PC+imm (branch taken); 0 = PC+4.
- `o_pc_inc`  out  ADDR_W  constant 4; provided for the PC adder.
- `o_finish`  out  1  high while halted.

## Operation
- States: RST, FETCH, IWAIT, EXEC, MEM, DWAIT, WB, HALT. State register resets to RST.
- RST → FETCH unconditionally.
- FETCH: `o_i_MemRead`=1 for exactly one cycle, then go to IWAIT.
- IWAIT: hold until `i_i_valid_inst`=1. On that cycle, latch `i_inst` into `o_inst` and go to EXEC.
- EXEC: decode `o_inst[6:0]`; drive `o_alu_src`, `o_alu_op`.
  - R (0110011) / I (0010011): go to WB.
  - Load (0000011) / store (0100011): go to MEM.
  - Branch (1100011): compute taken = funct3==000 ? zero : funct3==001 ? !zero : 0. Register taken into `pc_src_q`, then go to WB.
  - Halt (1111111) or any other opcode: go to HALT.
- MEM: one-cycle pulse, `o_d_MemRead` (load) or `o_d_MemWrite` (store), then go to DWAIT.
- DWAIT: hold until `i_d_valid_data`=1, then go to WB.
- WB:
  - `o_pc_write`=1.
  - `o_reg_write`=1 for R, I and load only.
  - `o_mem_to_reg`=1 for load.
  - `o_pc_src`=`pc_src_q`.
  - Next state: FETCH.
- HALT: absorbing. `o_finish`=1; no further requests. Only reset exits.
- `o_alu_src`, `o_alu_op` and `o_mem_to_reg` are held stable from EXEC through WB for the current instruction.
- `i_i_valid_inst` outside IWAIT and `i_d_valid_data` outside DWAIT are ignored.

## Timing
- All strobes are Moore decodes of the registered state, so they are glitch-free.
- Reset values: every output is 0 except `o_pc_inc`=4; `o_inst`=0; `pc_src_q`=0.
- Reset asserted mid-instruction: state → RST immediately. Any outstanding request is abandoned and a pending write-back is dropped.
- A response strobe arriving in the same cycle as its request (FETCH/MEM) is ignored; responses are accepted one cycle after the request at the earliest.
- Minimum cycles per instruction, with single-cycle memory response (excluding RST):
  - R, I and branch: 4 (FETCH, IWAIT, EXEC, WB).
  - Load and store: 6.
- `o_pc_write` and `o_reg_write` assert in the same cycle, exactly once per retired instruction.

## Structure
- Shared package `cpu_pkg`: opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_HALT), the `alu_op` encodings, and the state enum.
- One sub-module, `ctrl_decode`: purely combinational opcode/funct3 → {alu_src, alu_op, mem_to_reg, reg_write_en, is_mem, is_load, is_branch, is_halt}. The FSM instantiates it on `o_inst`.

## Test plan
- Reset release, then `i_inst`=0x00B50533 (add) with valid one cycle after the fetch pulse → `o_i_MemRead` pulses once; WB on cycle 4 with `o_reg_write`=1, `o_pc_write`=1, `o_alu_op`=10, `o_pc_src`=0.
- Load 0x0082B283, data valid 3 cycles after `o_d_MemRead` → single `o_d_MemRead` pulse; WB with `o_mem_to_reg`=1, `o_reg_write`=1.
- Store 0x0062B423 → `o_d_MemWrite` single pulse, `o_alu_src`=1; WB with `o_reg_write`=0, `o_pc_write`=1.
- beq 0x00208463 with `i_alu_zero`=1 → `o_pc_src`=1 in WB. Same instruction with zero=0 → `o_pc_src`=0. bne 0x00209463 with zero=0 → `o_pc_src`=1.
- Instruction 0xFFFFFFFF → HALT; `o_finish`=1 and stays 1 for 20 cycles with no request strobes. A stray `i_i_valid_inst` is ignored.
- Assert reset during DWAIT of a load → no `o_reg_write`; after release the FSM passes RST → FETCH and the first request is `o_i_MemRead`.

Source files
------------

// File: rtl/cpu_ctrl_fsm_pkg.sv
// Shared opcodes, ALU-op encodings, sequencer states and decode bundle for the CPU control path.
// Latency: none (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_HALT   = 7'b1111111;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10
    } alu_op_t;

    typedef enum logic [2:0] {
        ST_RST,
        ST_FETCH,
        ST_IWAIT,
        ST_EXEC,
        ST_MEM,
        ST_DWAIT,
        ST_WB,
        ST_HALT
    } state_t;

    typedef struct packed {
        logic    alu_src;
        alu_op_t alu_op;
        logic    mem_to_reg;
        logic    reg_write_en;
        logic    is_mem;
        logic    is_load;
        logic    is_branch;
        logic    is_halt;
    } dec_t;

    // Unknown branch funct3 values fall through to not-taken.
    function automatic logic branch_taken(input logic [2:0] funct3, input logic zero);
        case (funct3)
            F3_BEQ:  return zero;
            F3_BNE:  return !zero;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cpu_ctrl_fsm_if.sv
// Handshake bundle between the control sequencer and instruction/data memory plus decode datapath.
// Latency: none (wiring only).
// Backpressure: memories answer with single-cycle valid strobes; the sequencer waits indefinitely.
interface cpu_ctrl_if #(
    parameter int ADDR_W = 64
);
    logic [31:0]       i_inst;
    logic              i_i_valid_inst;
    logic              i_d_valid_data;
    logic              i_alu_zero;

    logic [31:0]       o_inst;
    logic              o_i_MemRead;
    logic              o_d_MemRead;
    logic              o_d_MemWrite;
    logic              o_alu_src;
    logic [1:0]        o_alu_op;
    logic              o_mem_to_reg;
    logic              o_reg_write;
    logic              o_pc_write;
    logic              o_pc_src;
    logic [ADDR_W-1:0] o_pc_inc;
    logic              o_finish;

    modport master (
        input  i_inst, i_i_valid_inst, i_d_valid_data, i_alu_zero,
        output o_inst, o_i_MemRead, o_d_MemRead, o_d_MemWrite, o_alu_src, o_alu_op,
               o_mem_to_reg, o_reg_write, o_pc_write, o_pc_src, o_pc_inc, o_finish
    );

    modport slave (
        output i_inst, i_i_valid_inst, i_d_valid_data, i_alu_zero,
        input  o_inst, o_i_MemRead, o_d_MemRead, o_d_MemWrite, o_alu_src, o_alu_op,
               o_mem_to_reg, o_reg_write, o_pc_write, o_pc_src, o_pc_inc, o_finish
    );
endinterface

// File: rtl/cpu_ctrl_fsm_ctrl_decode.sv
// Opcode to control-bundle decode; anything unrecognised is treated as halt.
// Latency: combinational.
// Backpressure: n/a.
module ctrl_decode
    import cpu_pkg::*;
(
    input  logic [6:0] opcode,
    output dec_t       dec
);

    always_comb begin
        dec        = '0;
        dec.alu_op = ALU_ADD;
        case (opcode)
            OP_R: begin
                dec.alu_op       = ALU_FUNCT;
                dec.reg_write_en = 1'b1;
            end
            OP_I: begin
                dec.alu_src      = 1'b1;
                dec.alu_op       = ALU_FUNCT;
                dec.reg_write_en = 1'b1;
            end
            OP_LOAD: begin
                dec.alu_src      = 1'b1;
                dec.mem_to_reg   = 1'b1;
                dec.reg_write_en = 1'b1;
                dec.is_mem       = 1'b1;
                dec.is_load      = 1'b1;
            end
            OP_STORE: begin
                dec.alu_src = 1'b1;
                dec.is_mem  = 1'b1;
            end
            OP_BRANCH: begin
                dec.alu_op    = ALU_SUB;
                dec.is_branch = 1'b1;
            end
            default: dec.is_halt = 1'b1;
        endcase
    end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle fetch/exec/mem/write-back sequencer; strobes are registered one-cycle pulses.
// Latency: 4 cycles per R/I/branch, 6+ per load/store (FETCH to WB inclusive, 1-cycle memories).
// Backpressure: IWAIT/DWAIT hold until the matching response strobe; responses elsewhere are dropped.
module cpu_ctrl_fsm
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 64
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    cpu_ctrl_if.master  bus
);

    localparam logic [ADDR_W-1:0] PC_INC = ADDR_W'(4);

    state_t      state;
    logic [31:0] inst_q;
    logic        pc_src_q;
    logic        dec_vld;
    logic        i_rd_q;
    logic        d_rd_q;
    logic        d_wr_q;
    logic        reg_wr_q;
    logic        pc_wr_q;
    logic        pc_src_out_q;
    logic        finish_q;
    dec_t        dec;
    logic        taken;

    ctrl_decode u_decode (
        .opcode (inst_q[6:0]),
        .dec    (dec)
    );

    assign taken = dec.is_branch && branch_taken(inst_q[14:12], bus.i_alu_zero);

    // Strobes are computed from the next state so they line up with the state they belong to.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= ST_RST;
            inst_q       <= '0;
            pc_src_q     <= 1'b0;
            dec_vld      <= 1'b0;
            i_rd_q       <= 1'b0;
            d_rd_q       <= 1'b0;
            d_wr_q       <= 1'b0;
            reg_wr_q     <= 1'b0;
            pc_wr_q      <= 1'b0;
            pc_src_out_q <= 1'b0;
            finish_q     <= 1'b0;
        end else begin
            i_rd_q       <= 1'b0;
            d_rd_q       <= 1'b0;
            d_wr_q       <= 1'b0;
            reg_wr_q     <= 1'b0;
            pc_wr_q      <= 1'b0;
            pc_src_out_q <= 1'b0;
            case (state)
                ST_RST: begin
                    state  <= ST_FETCH;
                    i_rd_q <= 1'b1;
                end
                ST_FETCH: state <= ST_IWAIT;
                ST_IWAIT: begin
                    if (bus.i_i_valid_inst) begin
                        inst_q  <= bus.i_inst;
                        dec_vld <= 1'b1;
                        state   <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    pc_src_q <= taken;
                    if (dec.is_halt) begin
                        dec_vld  <= 1'b0;
                        finish_q <= 1'b1;
                        state    <= ST_HALT;
                    end else if (dec.is_mem) begin
                        d_rd_q <= dec.is_load;
                        d_wr_q <= !dec.is_load;
                        state  <= ST_MEM;
                    end else begin
                        pc_wr_q      <= 1'b1;
                        reg_wr_q     <= dec.reg_write_en;
                        pc_src_out_q <= taken;
                        state        <= ST_WB;
                    end
                end
                ST_MEM: state <= ST_DWAIT;
                ST_DWAIT: begin
                    if (bus.i_d_valid_data) begin
                        pc_wr_q      <= 1'b1;
                        reg_wr_q     <= dec.reg_write_en;
                        pc_src_out_q <= pc_src_q;
                        state        <= ST_WB;
                    end
                end
                ST_WB: begin
                    dec_vld <= 1'b0;
                    i_rd_q  <= 1'b1;
                    state   <= ST_FETCH;
                end
                ST_HALT: state <= ST_HALT;
                default: state <= ST_RST;
            endcase
        end
    end

    // Decode fields stay valid from EXEC through WB because inst_q only changes on an accepted fetch.
    assign bus.o_inst       = inst_q;
    assign bus.o_alu_src    = dec_vld && dec.alu_src;
    assign bus.o_alu_op     = dec_vld ? dec.alu_op : ALU_ADD;
    assign bus.o_mem_to_reg = dec_vld && dec.mem_to_reg;
    assign bus.o_i_MemRead  = i_rd_q;
    assign bus.o_d_MemRead  = d_rd_q;
    assign bus.o_d_MemWrite = d_wr_q;
    assign bus.o_reg_write  = reg_wr_q;
    assign bus.o_pc_write   = pc_wr_q;
    assign bus.o_pc_src     = pc_src_out_q;
    assign bus.o_pc_inc     = PC_INC;
    assign bus.o_finish     = finish_q;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Randomised bench for cpu_ctrl_fsm: reactive memory responder plus an instruction-level expectation model.
module tb_cpu_ctrl_fsm;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cpu_ctrl_if #(.ADDR_W(64)) bus ();

    cpu_ctrl_fsm #(.ADDR_W(64)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit       mem;
        bit       load;
        bit       halt;
        bit       rw;
        bit       m2r;
        bit       asrc;
        bit [1:0] aop;
        bit       pcsrc;
    } exp_t;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // What one instruction must do, straight from the opcode table.
    function automatic exp_t model(input bit [31:0] inst, input bit zero);
        exp_t e;
        bit [2:0] f3;
        f3 = inst[14:12];
        e.mem = 0; e.load = 0; e.halt = 0; e.rw = 0; e.m2r = 0; e.asrc = 0; e.aop = 2'b00; e.pcsrc = 0;
        case (inst[6:0])
            7'b0110011: begin e.rw = 1; e.aop = 2'b10; end
            7'b0010011: begin e.rw = 1; e.asrc = 1; e.aop = 2'b10; end
            7'b0000011: begin e.mem = 1; e.load = 1; e.rw = 1; e.m2r = 1; e.asrc = 1; end
            7'b0100011: begin e.mem = 1; e.asrc = 1; end
            7'b1100011: begin e.aop = 2'b01; e.pcsrc = (f3 == 3'd0 && zero) || (f3 == 3'd1 && !zero); end
            default:    e.halt = 1;
        endcase
        return e;
    endfunction

    task automatic reset_checks();
        chk("rst_inst", bus.o_inst, 0);
        chk("rst_strobes", {bus.o_i_MemRead, bus.o_d_MemRead, bus.o_d_MemWrite, bus.o_reg_write, bus.o_pc_write}, 0);
        chk("rst_ctrl", {bus.o_alu_src, bus.o_alu_op, bus.o_mem_to_reg, bus.o_pc_src, bus.o_finish}, 0);
        chk("rst_pc_inc", bus.o_pc_inc, 64'd4);
    endtask

    // Serves one instruction: answers the fetch idly cycles after IWAIT starts, the data request ddly
    // cycles after DWAIT starts, and throws stray strobes wherever they must be ignored.
    task automatic run_inst(input bit [31:0] inst, input bit zero, input int idly, input int ddly, input bit abort);
        exp_t e;
        int cyc, done_cyc, t_req, ireqs, rds, wrs, rwp, icnt, dcnt, exp_cyc;
        bit in_dwait;
        e = model(inst, zero);
        cyc = 0; done_cyc = -1; t_req = -1; ireqs = 0; rds = 0; wrs = 0; rwp = 0;
        icnt = -1; dcnt = -1; in_dwait = 0;
        bus.i_alu_zero = zero;
        while (cyc < 60 && done_cyc < 0) begin
            @(negedge clk);
            if (abort && in_dwait) begin
                bus.i_d_valid_data = 1'b1;
                rst_n = 1'b0;
                return;
            end
            bus.i_i_valid_inst = 1'b0;
            bus.i_inst = $urandom;
            if (bus.o_i_MemRead === 1'b1) begin
                ireqs++;
                if (t_req < 0) t_req = cyc;
                icnt = idly + 1;
                bus.i_i_valid_inst = 1'($urandom_range(0, 1));
                bus.i_inst = 32'hFFFF_FFFF;
            end else if (icnt > 0) begin
                icnt--;
                if (icnt == 0) begin
                    bus.i_i_valid_inst = 1'b1;
                    bus.i_inst = inst;
                    icnt = -1;
                end
            end else begin
                bus.i_i_valid_inst = 1'($urandom_range(0, 1));
            end
            bus.i_d_valid_data = 1'b0;
            if (bus.o_d_MemRead === 1'b1 || bus.o_d_MemWrite === 1'b1) begin
                if (bus.o_d_MemRead === 1'b1) rds++;
                if (bus.o_d_MemWrite === 1'b1) wrs++;
                dcnt = ddly + 1;
                in_dwait = abort;
                bus.i_d_valid_data = 1'($urandom_range(0, 1));
                chk("mem_alu_src", bus.o_alu_src, e.asrc);
                chk("mem_alu_op", bus.o_alu_op, e.aop);
            end else if (dcnt > 0) begin
                dcnt--;
                if (dcnt == 0) begin
                    bus.i_d_valid_data = 1'b1;
                    dcnt = -1;
                end
            end else begin
                bus.i_d_valid_data = 1'($urandom_range(0, 1));
            end
            if (bus.o_reg_write === 1'b1) rwp++;
            if (bus.o_pc_write === 1'b1 || bus.o_finish === 1'b1) begin
                done_cyc = cyc;
                if (e.halt) begin
                    chk("halt_finish", bus.o_finish, 1);
                    chk("halt_no_pc_write", bus.o_pc_write, 0);
                end else begin
                    chk("wb_pc_write", bus.o_pc_write, 1);
                    chk("wb_reg_write", bus.o_reg_write, e.rw);
                    chk("wb_mem_to_reg", bus.o_mem_to_reg, e.m2r);
                    chk("wb_alu_src", bus.o_alu_src, e.asrc);
                    chk("wb_alu_op", bus.o_alu_op, e.aop);
                    chk("wb_pc_src", bus.o_pc_src, e.pcsrc);
                    chk("wb_inst", bus.o_inst, inst);
                    chk("wb_finish", bus.o_finish, 0);
                end
            end
            cyc++;
        end
        if (abort) begin
            chk("abort_reached_dwait", 0, 1);
            return;
        end
        exp_cyc = e.mem ? 5 + idly + ddly : 3 + idly;
        chk("retire_cycle", done_cyc, exp_cyc);
        chk("fetch_first_cycle", t_req, 0);
        chk("fetch_pulses", ireqs, 1);
        chk("load_pulses", rds, e.load);
        chk("store_pulses", wrs, e.mem && !e.load);
        chk("reg_write_pulses", rwp, e.rw);
    endtask

    initial begin
        bit [6:0] ops [5];
        ops[0] = 7'b0110011; ops[1] = 7'b0010011; ops[2] = 7'b0000011;
        ops[3] = 7'b0100011; ops[4] = 7'b1100011;

        bus.i_inst = '0;
        bus.i_i_valid_inst = 1'b0;
        bus.i_d_valid_data = 1'b0;
        bus.i_alu_zero = 1'b0;
        repeat (3) @(negedge clk);
        reset_checks();
        rst_n = 1'b1;

        run_inst(32'h00B50533, 1'b0, 0, 0, 1'b0);
        run_inst(32'h0082B283, 1'b0, 0, 2, 1'b0);
        run_inst(32'h0062B423, 1'b0, 1, 0, 1'b0);
        run_inst(32'h00208463, 1'b1, 0, 0, 1'b0);
        run_inst(32'h00208463, 1'b0, 0, 0, 1'b0);
        run_inst(32'h00209463, 1'b0, 2, 0, 1'b0);
        run_inst(32'h00209463, 1'b1, 0, 0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            bit [31:0] ins;
            ins = $urandom;
            ins[6:0] = ops[$urandom_range(0, 4)];
            run_inst(ins, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0);
        end

        // Reset lands in DWAIT of a load with the data strobe already up: the write-back must vanish.
        run_inst(32'h0082B283, 1'b0, 0, 1, 1'b1);
        #1;
        reset_checks();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bus.i_d_valid_data = 1'b0;
            chk("rst_hold_no_wb", {bus.o_reg_write, bus.o_pc_write, bus.o_i_MemRead}, 0);
        end
        rst_n = 1'b1;
        run_inst(32'h00B50533, 1'b0, 0, 0, 1'b0);

        run_inst(32'hFFFF_FFFF, 1'b0, 1, 0, 1'b0);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            bus.i_i_valid_inst = 1'($urandom_range(0, 1));
            bus.i_inst = 32'h00B50533;
            bus.i_d_valid_data = 1'($urandom_range(0, 1));
            chk("halt_hold_finish", bus.o_finish, 1);
            chk("halt_hold_quiet", {bus.o_i_MemRead, bus.o_d_MemRead, bus.o_d_MemWrite, bus.o_reg_write, bus.o_pc_write}, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
